relay_link_rx: RTL and testbench
================================

Name: relay_link_rx

Overview:
- Receive front end for the inter-Proxmark relay line, upstream of the relay SSP/ARM stage.
- Synchronises the asynchronous `data_in` wire from the peer Proxmark and locks onto each frame's 4-bit preamble.
- Deserialises the framed byte, checks parity and queues good bytes in a small FIFO, where the downstream stage pops them with a valid/ready handshake.
- Emits a one-cycle start-of-frame pulse; the relay delay counter uses it as its stop event.

Parameters:
- BIT_PERIOD, 16: `ck_1356meg` cycles per line bit (847.5 kbit/s); must be even and ≥ 4.
- PREAMBLE, 4'b1010: preamble pattern, sent MSB first; MSB must be 1.
- FIFO_AW, 2: FIFO address width; depth = 2^FIFO_AW = 4 entries.

Ports:
- `ck_1356meg`, in, 1: 13.56 MHz clock, the only clock.
- `nreset`, in, 1: asynchronous active-low reset.
- `data_in`, in, 1: relay line from the peer, asynchronous; idle level 0.
- `enable`, in, 1: 0 forces HUNT and holds the FIFO contents.
- `rx_data`, out, 8: byte at the FIFO head.
- `rx_valid`, out, 1: FIFO not empty.
- `rx_ready`, in, 1: pop the head when `rx_valid` and `rx_ready` are both high.
- `sof`, out, 1: one-cycle pulse when a full preamble has matched.
- `parity_err`, out, 1: one-cycle pulse when a frame is dropped for bad parity.
- `overrun`, out, 1: sticky flag, set when a good frame is dropped because the FIFO is full.
- `overrun_clr`, in, 1: clears `overrun`.

Behaviour:
- Frame on the line, MSB first: PREAMBLE (4 bits), 8 data bits, 1 even-parity bit over the data, then ≥ 1 idle bit at 0. Total 13 bits plus idle.
- Synchroniser: two flip-flops on `data_in` giving `din_s`; a third register holds `din_d` for edge detect. A rise is `din_s & ~din_d`.
- State machine: HUNT, PRE, DATA, PAR, GAP.
- HUNT:
  - On a rise while `enable` is high: load bit timer `t` = 0, `idx` = 0, go to PRE.
  - Samples are taken on cycles where `t == BIT_PERIOD/2 - 1`.
  - `t` counts 0..BIT_PERIOD-1 and wraps to 0, giving one sample per bit.
- PRE:
  - Compare each sample against `PREAMBLE[3-idx]`.
  - Mismatch: back to HUNT, no pulse (glitch or misalignment).
  - After the 4th match: assert `sof` for exactly 1 cycle on the following cycle, then go to DATA.
- DATA: shift samples into an 8-bit shift register MSB first; after 8 samples go to PAR.
- PAR: on the sample, decide the frame:
  - XOR of the 8 data bits and the parity sample is 1: pulse `parity_err`, drop the frame.
  - Otherwise, FIFO full: set `overrun`, drop the frame.
  - Otherwise: write the byte into the FIFO.
  - In every case go to GAP.
- GAP: wait until `din_s == 0` at a sample point, then go to HUNT. This prevents a stuck-high line from re-triggering.
- `enable` low in any state: HUNT next cycle; partial frame discarded; no pulses.
- FIFO:
  - Write and read pointers are FIFO_AW+1 bits wide.
  - Empty when the pointers are equal; full when the MSBs differ and the rest are equal.
  - `rx_data` is the combinational head; it is 8'h00 when empty.
  - A write and a pop in the same cycle are both performed, even when full: the pop frees a slot, so the write succeeds and `overrun` is not set.
- `overrun_clr` and a new overrun in the same cycle: `overrun` stays 1.
- Latency: the byte appears on `rx_valid` 1 cycle after the parity sample cycle. The line-to-sample delay is 3 cycles of synchroniser plus edge register.
- Reset (async assert, release on a clock edge):
  - State HUNT; timers, shift register and FIFO pointers cleared.
  - All outputs 0: `rx_data`=0, `rx_valid`=0, `sof`=0, `parity_err`=0, `overrun`=0.
  - Reset mid-frame discards the frame; the next frame must begin with a fresh rise.

Test Plan:
- Reset, then send frame 1010 + 0xA5 + parity 0, 16 cycles/bit, with `rx_ready`=1 → `sof` pulses once, `rx_valid` pulses 1 cycle with `rx_data`=0xA5, `parity_err`=0.
- Send 0x3C with parity bit 1 → `parity_err` pulses once, `rx_valid` stays 0, FIFO empty.
- Hold `rx_ready`=0 and send 5 frames 0x01..0x05 → 4 entries held, `overrun`=1; then pop → 0x01, 0x02, 0x03, 0x04; `overrun_clr` → `overrun`=0.
- Send a preamble of 1000 and a 3-cycle high glitch → no `sof`, no `rx_valid`; a following valid 0x7E frame is received correctly.
- Fill the FIFO to 4 entries, and on the parity cycle of a 5th frame (0x99) assert `rx_ready` → no overrun; order is 0x01..0x04, then 0x99.
- Assert `nreset`=0 during data bit 3 → all outputs 0 immediately; after release, the next 0xC3 frame is received correctly.

Source files
------------

// File: rtl/relay_link_rx.sv
// Relay line receiver: synchronises the peer's serial line, locks onto the frame
// preamble, deserialises and parity-checks each byte, and queues good bytes in a small FIFO.
module relay_link_rx #(
  parameter int         BIT_PERIOD = 16,
  parameter logic [3:0] PREAMBLE   = 4'b1010,
  parameter int         FIFO_AW    = 2
) (
  input  logic       ck_1356meg,
  input  logic       nreset,
  input  logic       data_in,
  input  logic       enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       sof,
  output logic       parity_err,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam int TW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [TW-1:0] T_SAMPLE = TW'(BIT_PERIOD / 2 - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(BIT_PERIOD - 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {HUNT, PRE, DATA, PAR, GAP} state_t;

  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  state_t          state, state_nx;
  logic            din_meta, din_s, din_d;
  logic            rise, sample;
  logic [TW-1:0]   t;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            sof_set, perr_set, ovr_set, wr_en;
  logic [FIFO_AW:0] wptr, rptr;
  logic [7:0]      mem [DEPTH];
  logic            empty, full, pop;

  // Stage 0: two-flop synchroniser plus edge-detect register
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
      din_d    <= 1'b0;
    end else begin
      din_meta <= data_in;
      din_s    <= din_meta;
      din_d    <= din_s;
    end
  end

  assign rise   = din_s & ~din_d;
  assign sample = (t == T_SAMPLE);

  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign pop   = !empty && rx_ready;

  // Stage 1: frame state machine
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) state <= HUNT;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sof_set  = 1'b0;
    perr_set = 1'b0;
    ovr_set  = 1'b0;
    wr_en    = 1'b0;
    if (!enable) begin
      state_nx = HUNT;
    end else begin
      case (state)
        HUNT: if (rise) state_nx = PRE;
        PRE: if (sample) begin
          if (din_s != PREAMBLE[2'd3 - idx[1:0]]) begin
            state_nx = HUNT;
          end else if (idx == 3'd3) begin
            state_nx = DATA;
            sof_set  = 1'b1;
          end
        end
        DATA: if (sample && idx == 3'd7) state_nx = PAR;
        PAR: if (sample) begin
          state_nx = GAP;
          if (parity_bad(shreg, din_s)) perr_set = 1'b1;
          else if (full && !pop)        ovr_set  = 1'b1;
          else                          wr_en    = 1'b1;
        end
        GAP: if (sample && !din_s) state_nx = HUNT;
        default: state_nx = HUNT;
      endcase
    end
  end

  // Bit timer restarts on every HUNT cycle so the first sample lands mid-bit after the rise
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      t          <= '0;
      idx        <= '0;
      shreg      <= '0;
      sof        <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (state == HUNT)    t <= '0;
      else if (t == T_LAST) t <= '0;
      else                  t <= t + 1'b1;

      if (state == HUNT)
        idx <= '0;
      else if (sample && (state == PRE || state == DATA))
        idx <= (state_nx != state) ? 3'd0 : idx + 3'd1;

      if (enable && state == DATA && sample)
        shreg <= {shreg[6:0], din_s};

      sof        <= sof_set;
      parity_err <= perr_set;
      if (ovr_set)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  // Stage 2: byte FIFO; a pop in the write cycle frees the slot the write needs
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (wr_en) mem[wptr[FIFO_AW-1:0]] <= shreg;
  end

  assign rx_valid = !empty;
  assign rx_data  = empty ? 8'h00 : mem[rptr[FIFO_AW-1:0]];

endmodule

// File: tb/tb_relay_link_rx.sv
// Bench for relay_link_rx: table of single frames, randomized frames against a
// frame-level model, and hand sequences for FIFO full, overrun and mid-frame reset.
module tb_relay_link_rx;
  localparam int BP = 16;

  logic       ck_1356meg = 1'b0;
  logic       nreset, data_in, enable, rx_ready, overrun_clr;
  logic [7:0] rx_data;
  logic       rx_valid, sof, parity_err, overrun;

  relay_link_rx #(.BIT_PERIOD(BP), .PREAMBLE(4'b1010), .FIFO_AW(2)) dut (
    .ck_1356meg (ck_1356meg),
    .nreset     (nreset),
    .data_in    (data_in),
    .enable     (enable),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .sof        (sof),
    .parity_err (parity_err),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  int n_total = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge ck_1356meg) cyc <= cyc + 1;

  int   sof_cnt = 0, perr_cnt = 0, sof_cyc = 0, vrise_cyc = 0;
  int   vlen_cur = 0, vlen_last = 0, sof_wide = 0;
  logic vprev = 1'b0, sprev = 1'b0;
  logic [7:0] pop_q[$];

  always begin
    @(negedge ck_1356meg);
    #2;
    if (nreset) begin
      if (sof) begin sof_cnt++; sof_cyc = cyc; end
      if (sof && sprev) sof_wide++;
      if (parity_err) perr_cnt++;
      if (rx_valid && !vprev) begin vrise_cyc = cyc; vlen_cur = 0; end
      if (rx_valid) vlen_cur++;
      else if (vprev) vlen_last = vlen_cur;
      if (rx_valid && rx_ready) pop_q.push_back(rx_data);
    end
    vprev = rx_valid && nreset;
    sprev = sof && nreset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge ck_1356meg);
    #1;
  endtask

  // One frame of nbits line bits followed by idle zeros; optional one-cycle
  // rx_ready / overrun_clr pulses and an asynchronous reset at chosen cycles.
  task automatic send_frame(input logic [3:0] pre, input logic [7:0] d, input logic flip,
                            input int nbits, input int idle, input int ready_at,
                            input int clr_at, input int rst_at, output int start);
    logic [12:0] fr;
    int total, b;
    fr    = {pre, d, ^d ^ flip};
    total = (nbits + idle) * BP;
    start = cyc;
    for (int k = 0; k < total; k++) begin
      b = k / BP;
      data_in = (b < nbits) ? fr[12-b] : 1'b0;
      if (ready_at >= 0 && k == ready_at)     rx_ready = 1'b1;
      if (ready_at >= 0 && k == ready_at + 1) rx_ready = 1'b0;
      if (clr_at >= 0 && k == clr_at)         overrun_clr = 1'b1;
      if (clr_at >= 0 && k == clr_at + 1)     overrun_clr = 1'b0;
      if (k == rst_at) begin
        nreset = 1'b0;
        #1;
        chk("rst_mid_valid", rx_valid, 1'b0);
        chk("rst_mid_data", rx_data, 8'h00);
        chk("rst_mid_sof", sof, 1'b0);
        chk("rst_mid_perr", parity_err, 1'b0);
        chk("rst_mid_ovr", overrun, 1'b0);
        data_in = 1'b0;
        tick();
        break;
      end
      tick();
    end
    data_in = 1'b0;
  endtask

  task automatic good(input logic [7:0] d);
    int s;
    send_frame(4'b1010, d, 1'b0, 13, 1, -1, -1, -1, s);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    repeat (8) tick();
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0] pre;
    logic [7:0] d;
    logic       flip;
    int         nbits;
    logic       e_sof;
    logic       e_perr;
    logic       e_valid;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[7];
  logic [7:0] exp_q[$];

  initial begin
    int s0, p0, q0, start, es, ep, kind, idle, nb;
    logic [7:0] d;
    logic [3:0] pre;
    logic flip;

    tbl[0] = '{4'b1010, 8'hA5, 1'b0, 13, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[1] = '{4'b1010, 8'h3C, 1'b1, 13, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{4'b1000, 8'h00, 1'b0,  4, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{4'b1010, 8'h7E, 1'b0, 13, 1'b1, 1'b0, 1'b1, 8'h7E};
    tbl[4] = '{4'b1010, 8'h00, 1'b0, 13, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[5] = '{4'b1010, 8'hFF, 1'b0, 13, 1'b1, 1'b0, 1'b1, 8'hFF};
    tbl[6] = '{4'b1010, 8'h81, 1'b1, 13, 1'b1, 1'b1, 1'b0, 8'h00};

    nreset = 1'b0; data_in = 1'b0; enable = 1'b1; rx_ready = 1'b1; overrun_clr = 1'b0;
    repeat (3) tick();
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_sof", sof, 1'b0);
    chk("reset_perr", parity_err, 1'b0);
    chk("reset_ovr", overrun, 1'b0);
    nreset = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 7; i++) begin
      s0 = sof_cnt; p0 = perr_cnt; q0 = pop_q.size();
      send_frame(tbl[i].pre, tbl[i].d, tbl[i].flip, tbl[i].nbits,
                 (tbl[i].nbits == 13) ? 1 : 4, -1, -1, -1, start);
      chk($sformatf("tbl%0d_sof", i), sof_cnt - s0, 32'(tbl[i].e_sof));
      chk($sformatf("tbl%0d_perr", i), perr_cnt - p0, 32'(tbl[i].e_perr));
      chk($sformatf("tbl%0d_pops", i), pop_q.size() - q0, 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_empty", i), rx_valid, 1'b0);
      if (tbl[i].e_sof) chk($sformatf("tbl%0d_sof_lat", i), sof_cyc - start, 59);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_vld_lat", i), vrise_cyc - start, 203);
        if (pop_q.size() > q0) chk($sformatf("tbl%0d_data", i), pop_q[q0], tbl[i].e_data);
      end
      if (i == 0) chk("tbl0_vld_width", vlen_last, 1);
    end

    // Short glitch must not lock, and the next frame still decodes
    s0 = sof_cnt; q0 = pop_q.size();
    data_in = 1'b1;
    repeat (3) tick();
    data_in = 1'b0;
    repeat (4 * BP) tick();
    chk("glitch_sof", sof_cnt - s0, 0);
    chk("glitch_pops", pop_q.size() - q0, 0);
    good(8'h7E);
    chk("post_glitch_pops", pop_q.size() - q0, 1);
    if (pop_q.size() > q0) chk("post_glitch_data", pop_q[q0], 8'h7E);

    // Randomized frames against a frame-level model
    pop_q.delete(); exp_q.delete();
    s0 = sof_cnt; p0 = perr_cnt; es = 0; ep = 0;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      d    = 8'($urandom);
      idle = $urandom_range(1, 3);
      pre  = 4'b1010; flip = 1'b0; nb = 13;
      if (kind < 7) begin
        exp_q.push_back(d); es++;
      end else if (kind < 9) begin
        flip = 1'b1; es++; ep++;
      end else begin
        do pre = {1'b1, 3'($urandom)}; while (pre == 4'b1010);
        nb = 4; idle = 4;
      end
      send_frame(pre, d, flip, nb, idle, -1, -1, -1, start);
    end
    chk("rand_sof_cnt", sof_cnt - s0, es);
    chk("rand_perr_cnt", perr_cnt - p0, ep);
    chk("rand_pop_cnt", pop_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++)
      chk($sformatf("rand_byte%0d", i), pop_q[i], exp_q[i]);

    // Overrun with a stalled consumer, clear, and clear colliding with a new overrun
    pop_q.delete(); rx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) good(8'(v));
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_head", rx_data, 8'h01);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 1'b0);
    send_frame(4'b1010, 8'h06, 1'b0, 13, 1, -1, 202, -1, start);
    chk("ovr_clr_collide", overrun, 1'b1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    drain();
    chk("ovr_pop_cnt", pop_q.size(), 4);
    for (int i = 0; i < 4 && i < pop_q.size(); i++)
      chk($sformatf("ovr_byte%0d", i), pop_q[i], 32'(i + 1));
    chk("ovr_drained", rx_valid, 1'b0);

    // Pop in the same cycle as a write into a full FIFO
    pop_q.delete();
    for (int v = 1; v <= 4; v++) good(8'(v));
    send_frame(4'b1010, 8'h99, 1'b0, 13, 1, 202, -1, -1, start);
    chk("full_pop_ovr", overrun, 1'b0);
    drain();
    chk("full_pop_cnt", pop_q.size(), 5);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h99};
    for (int i = 0; i < 5 && i < pop_q.size(); i++)
      chk($sformatf("full_pop_byte%0d", i), pop_q[i], exp_q[i]);

    // Disabled receiver ignores a complete frame
    s0 = sof_cnt; q0 = pop_q.size();
    enable = 1'b0; rx_ready = 1'b1;
    good(8'hA5);
    chk("dis_sof", sof_cnt - s0, 0);
    chk("dis_pops", pop_q.size() - q0, 0);
    enable = 1'b1;

    // Reset during data bit 3 with a byte already queued
    rx_ready = 1'b0;
    good(8'h55);
    chk("rst_pre_valid", rx_valid, 1'b1);
    send_frame(4'b1010, 8'h5A, 1'b0, 13, 1, -1, -1, 7 * BP + 5, start);
    repeat (3) tick();
    nreset = 1'b1; rx_ready = 1'b1;
    repeat (2 * BP) tick();
    s0 = sof_cnt; q0 = pop_q.size();
    send_frame(4'b1010, 8'hC3, 1'b0, 13, 1, -1, -1, -1, start);
    chk("rst_after_sof", sof_cnt - s0, 1);
    chk("rst_after_pops", pop_q.size() - q0, 1);
    if (pop_q.size() > q0) chk("rst_after_data", pop_q[q0], 8'hC3);
    chk("sof_width", sof_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
